// File: rtl/jacobi_1d_sched.sv
// Ping-pong scheduler for a 1-D Jacobi kernel: issues one component call per
// timestep, swapping source and scratch arrays, and reports the final array.
module jacobi_1d_sched #(
    parameter int AW  = 64,
    parameter int SW  = 16,
    parameter int TMO = 65535
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          job_valid,
    output logic          job_ready,
    input  logic [AW-1:0] job_src,
    input  logic [AW-1:0] job_dst,
    input  logic [SW-1:0] job_steps,
    output logic          comp_start,
    input  logic          comp_busy,
    output logic [AW-1:0] comp_A_1,
    output logic [AW-1:0] comp_A_2,
    output logic [AW-1:0] comp_B,
    input  logic          comp_done,
    output logic          comp_stall,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [AW-1:0] res_addr,
    output logic          res_err,
    output logic [SW-1:0] steps_done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALL = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    // Counter spans 0..TMO-1 inside WAIT; TMO=1 still needs one bit.
    localparam int            CW       = (TMO > 1) ? $clog2(TMO) : 1;
    localparam logic [CW-1:0] TMO_LAST = CW'(TMO - 1);

    logic [1:0]    state;
    logic [AW-1:0] cur_src;
    logic [AW-1:0] cur_dst;
    logic [SW-1:0] remaining;
    logic [CW-1:0] tmo_cnt;

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values; the src/dst swap relies on this.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            cur_src    <= '0;
            cur_dst    <= '0;
            remaining  <= '0;
            tmo_cnt    <= '0;
            steps_done <= '0;
            res_addr   <= '0;
            res_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (job_valid) begin
                        cur_src    <= job_src;
                        cur_dst    <= job_dst;
                        remaining  <= job_steps;
                        steps_done <= '0;
                        if (job_steps != '0) begin
                            state <= CALL;
                        end else begin
                            res_addr <= job_src;
                            res_err  <= 1'b0;
                            state    <= RESP;
                        end
                    end
                end
                CALL: begin
                    if (!comp_busy) begin
                        state   <= WAIT;
                        tmo_cnt <= '0;
                    end
                end
                WAIT: begin
                    // A return in the final counted cycle beats the timeout.
                    if (comp_done) begin
                        cur_src    <= cur_dst;
                        cur_dst    <= cur_src;
                        steps_done <= steps_done + 1'b1;
                        remaining  <= remaining - 1'b1;
                        if (remaining != SW'(1)) begin
                            state <= CALL;
                        end else begin
                            res_addr <= cur_dst;
                            res_err  <= 1'b0;
                            state    <= RESP;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        res_addr <= cur_src;
                        res_err  <= 1'b1;
                        state    <= RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (res_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign job_ready  = (state == IDLE);
    assign comp_start = (state == CALL);
    assign comp_stall = (state != WAIT);
    assign res_valid  = (state == RESP);
    assign comp_A_1   = cur_src;
    assign comp_A_2   = cur_src;
    assign comp_B     = cur_dst;

endmodule

// File: tb/tb_jacobi_1d_sched.sv
// Bench for jacobi_1d_sched: component/handshake model plus a per-cycle
// scoreboard of expected calls, results and timestep counts.
module tb_jacobi_1d_sched;

    localparam int AW  = 64;
    localparam int SW  = 8;
    localparam int TMO = 8;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [AW-1:0] b;
    } call_t;

    logic          clock;
    logic          resetn;
    logic          job_valid;
    logic          job_ready;
    logic [AW-1:0] job_src;
    logic [AW-1:0] job_dst;
    logic [SW-1:0] job_steps;
    logic          comp_start;
    logic          comp_busy;
    logic [AW-1:0] comp_A_1;
    logic [AW-1:0] comp_A_2;
    logic [AW-1:0] comp_B;
    logic          comp_done;
    logic          comp_stall;
    logic          res_valid;
    logic          res_ready;
    logic [AW-1:0] res_addr;
    logic          res_err;
    logic [SW-1:0] steps_done;

    jacobi_1d_sched #(.AW(AW), .SW(SW), .TMO(TMO)) dut (
        .clock(clock), .resetn(resetn),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_src(job_src), .job_dst(job_dst), .job_steps(job_steps),
        .comp_start(comp_start), .comp_busy(comp_busy),
        .comp_A_1(comp_A_1), .comp_A_2(comp_A_2), .comp_B(comp_B),
        .comp_done(comp_done), .comp_stall(comp_stall),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_addr(res_addr), .res_err(res_err), .steps_done(steps_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Job request and component behaviour, set by the main sequence.
    logic          req_pending = 1'b0;
    logic [AW-1:0] req_src = '0;
    logic [AW-1:0] req_dst = '0;
    logic [SW-1:0] req_steps = '0;
    int            cfg_lat = 1;   // WAIT cycle on which done rises; 0 = never
    int            cfg_busy = 0;  // busy cycles seen by each call
    int            cfg_ready = 0; // RESP cycles before res_ready rises
    logic          cfg_spur = 1'b0;

    // Expected behaviour and observed timing.
    call_t         exp_calls[$];
    logic [AW-1:0] exp_addr = '0;
    logic          exp_err = 1'b0;
    int            exp_steps = 0;
    logic          mdl_idle = 1'b1;
    int            model_done = 0;
    logic          outstanding = 1'b0;
    int            wait_cnt = 0;
    int            busy_cnt = 0;
    int            resp_cnt = 0;
    int            resp_samples = 0;
    int            call_cnt = 0;
    logic          job_complete = 1'b0;
    int            cyc_n = 0;
    int            job_acc_cyc = 0;
    int            call_acc_cyc = 0;
    int            first_start_cyc = -1;
    int            res_first_cyc = 0;
    logic          hold_prev = 1'b0;
    logic [AW-1:0] prev_a = '0;
    logic [AW-1:0] prev_b = '0;

    // Drive at the falling edge, then sample what the next rising edge will see.
    initial begin : cycle_proc
        logic ret;
        call_t c;
        job_valid = 1'b0; job_src = '0; job_dst = '0; job_steps = '0;
        comp_busy = 1'b0; comp_done = 1'b0; res_ready = 1'b0;
        forever begin
            @(negedge clock);
            job_valid = req_pending;
            job_src   = req_src;
            job_dst   = req_dst;
            job_steps = req_steps;
            comp_busy = (busy_cnt < cfg_busy);
            comp_done = (outstanding && cfg_lat != 0 && wait_cnt + 1 >= cfg_lat) ||
                        (cfg_spur && busy_cnt > 0 && busy_cnt < cfg_busy);
            res_ready = (resp_cnt >= cfg_ready);
            #2;
            cyc_n++;
            if (!resetn) begin
                check("no_resp_in_reset", res_valid, 1'b0);
                exp_calls.delete();
                outstanding = 1'b0; mdl_idle = 1'b1; model_done = 0;
                req_pending = 1'b0; hold_prev = 1'b0; busy_cnt = 0; resp_cnt = 0;
            end else begin
                if (hold_prev) begin
                    check("start_held", comp_start, 1'b1);
                    check("A_1_held", comp_A_1, prev_a);
                    check("B_held", comp_B, prev_b);
                end
                hold_prev = comp_start && comp_busy;
                prev_a = comp_A_1;
                prev_b = comp_B;
                check("job_ready", job_ready, mdl_idle);
                check("steps_done", steps_done, model_done);
                if (comp_start) begin
                    check("A_1_eq_A_2", comp_A_2, comp_A_1);
                    if (first_start_cyc < 0) first_start_cyc = cyc_n;
                end
                ret = comp_done && !comp_stall;
                if (ret) begin
                    if (!outstanding) check("spurious_return", 1'b1, 1'b0);
                    outstanding = 1'b0;
                    model_done++;
                end else if (outstanding) begin
                    wait_cnt++;
                end
                if (comp_start && comp_busy) busy_cnt++;
                if (comp_start && !comp_busy) begin
                    check("one_outstanding", outstanding, 1'b0);
                    if (exp_calls.size() == 0) begin
                        check("unexpected_call", 1'b1, 1'b0);
                    end else begin
                        c = exp_calls.pop_front();
                        check("call_A", comp_A_1, c.a);
                        check("call_B", comp_B, c.b);
                    end
                    outstanding = 1'b1; wait_cnt = 0; busy_cnt = 0;
                    call_cnt++; call_acc_cyc = cyc_n;
                end
                if (res_valid) begin
                    if (resp_cnt == 0) res_first_cyc = cyc_n;
                    check("res_addr", res_addr, exp_addr);
                    check("res_err", res_err, exp_err);
                    check("res_steps_done", steps_done, exp_steps);
                    check("calls_left_at_resp", exp_calls.size(), 0);
                    resp_cnt++;
                    if (res_ready) begin
                        resp_samples = resp_cnt;
                        resp_cnt = 0; mdl_idle = 1'b1; job_complete = 1'b1;
                        outstanding = 1'b0;
                    end
                end
                if (job_valid && job_ready) begin
                    req_pending = 1'b0; mdl_idle = 1'b0; model_done = 0;
                    job_acc_cyc = cyc_n;
                end
            end
        end
    end

    // Expected calls and result from the ping-pong rule alone.
    task automatic model_expect(input logic [AW-1:0] src, input logic [AW-1:0] dst,
                                input int steps, input logic tmo);
        exp_calls.delete();
        if (tmo) begin
            exp_calls.push_back({src, dst});
            exp_addr = src; exp_err = 1'b1; exp_steps = 0;
        end else begin
            for (int k = 0; k < steps; k++)
                exp_calls.push_back((k % 2 == 0) ? {src, dst} : {dst, src});
            exp_addr = (steps % 2 == 1) ? dst : src;
            exp_err = 1'b0; exp_steps = steps;
        end
    endtask

    task automatic launch(input logic [AW-1:0] src, input logic [AW-1:0] dst, input int steps);
        @(negedge clock);
        job_complete = 1'b0; call_cnt = 0; first_start_cyc = -1;
        req_src = src; req_dst = dst; req_steps = SW'(steps);
        req_pending = 1'b1;
    endtask

    task automatic wait_job(input string name, input int budget);
        for (int i = 0; i < budget && !job_complete; i++) @(negedge clock);
        check(name, job_complete, 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_job_ready"}, job_ready, 1'b1);
        check({tag, "_comp_start"}, comp_start, 1'b0);
        check({tag, "_comp_stall"}, comp_stall, 1'b1);
        check({tag, "_res_valid"}, res_valid, 1'b0);
        check({tag, "_res_err"}, res_err, 1'b0);
        check({tag, "_res_addr"}, res_addr, 64'h0);
        check({tag, "_A_1"}, comp_A_1, 64'h0);
        check({tag, "_A_2"}, comp_A_2, 64'h0);
        check({tag, "_B"}, comp_B, 64'h0);
        check({tag, "_steps_done"}, steps_done, 64'h0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        resetn = 1'b0;
        repeat (3) @(negedge clock);
        #1 check_reset_outputs("por");
        @(negedge clock);
        resetn = 1'b1;
        #1 check("ready_after_reset", job_ready, 1'b1);

        // Three steps, 5-cycle component: hand-derived call list and result.
        exp_calls.delete();
        exp_calls.push_back({64'h1000, 64'h2000});
        exp_calls.push_back({64'h2000, 64'h1000});
        exp_calls.push_back({64'h1000, 64'h2000});
        exp_addr = 64'h2000; exp_err = 1'b0; exp_steps = 3;
        cfg_lat = 5;
        launch(64'h1000, 64'h2000, 3);
        wait_job("A_done", 200);
        check("A_calls", call_cnt, 3);
        check("A_final_steps", steps_done, 3);

        // Zero steps: immediate response carrying the source array.
        exp_calls.delete();
        exp_addr = 64'h40; exp_err = 1'b0; exp_steps = 0;
        launch(64'h40, 64'h80, 0);
        wait_job("B_done", 50);
        check("B_calls", call_cnt, 0);
        check("B_latency", res_first_cyc - job_acc_cyc, 1);

        // Busy for 10 cycles with a stray done; accepted on the 11th.
        model_expect(64'h5000, 64'h6000, 1, 1'b0);
        cfg_busy = 10; cfg_spur = 1'b1; cfg_lat = 2;
        launch(64'h5000, 64'h6000, 1);
        wait_job("C_done", 100);
        check("C_accept_cycle", call_acc_cyc - first_start_cyc, 10);
        cfg_busy = 0; cfg_spur = 1'b0;

        // Component never returns: abort after TMO WAIT cycles.
        model_expect(64'h7000, 64'h8000, 2, 1'b1);
        cfg_lat = 0;
        launch(64'h7000, 64'h8000, 2);
        wait_job("D_done", 100);
        check("D_timeout_latency", res_first_cyc - call_acc_cyc, TMO + 1);
        check("D_calls", call_cnt, 1);

        // Return on the last counted cycle wins over the timeout.
        model_expect(64'h9000, 64'hA000, 2, 1'b0);
        cfg_lat = TMO;
        launch(64'h9000, 64'hA000, 2);
        wait_job("E_done", 100);
        check("E_final_addr", res_addr, 64'h9000);

        // Response back-pressured for 6 cycles.
        model_expect(64'hB000, 64'hC000, 1, 1'b0);
        cfg_lat = 1; cfg_ready = 6;
        launch(64'hB000, 64'hC000, 1);
        wait_job("F_done", 100);
        check("F_resp_cycles", resp_samples, 7);
        cfg_ready = 0;

        // Zero-latency component: two cycles per timestep.
        model_expect(64'h100, 64'h200, 4, 1'b0);
        cfg_lat = 1;
        launch(64'h100, 64'h200, 4);
        wait_job("G_done", 100);
        check("G_latency", res_first_cyc - job_acc_cyc, 2 * 4 + 1);

        // Reset while waiting on step 2 abandons the job silently.
        model_expect(64'h3000, 64'h4000, 3, 1'b0);
        cfg_lat = 5;
        launch(64'h3000, 64'h4000, 3);
        for (int i = 0; i < 100 && !(call_cnt == 2 && wait_cnt >= 2); i++) @(negedge clock);
        check("H_in_step2", call_cnt, 2);
        @(negedge clock);
        resetn = 1'b0;
        #1 check_reset_outputs("mid");
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        repeat (4) @(negedge clock);
        check("H_no_response", job_complete, 1'b0);
        model_expect(64'hD000, 64'hE000, 2, 1'b0);
        cfg_lat = 3;
        launch(64'hD000, 64'hE000, 2);
        wait_job("H_new_job_done", 100);

        // Maximum step count runs to completion without wrapping.
        model_expect(64'hF0, 64'hF8, (1 << SW) - 1, 1'b0);
        cfg_lat = 1;
        launch(64'hF0, 64'hF8, (1 << SW) - 1);
        wait_job("I_done", 2000);
        check("I_calls", call_cnt, (1 << SW) - 1);
        check("I_final_addr", res_addr, 64'hF8);

        repeat (2) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
